exe_mem_stage: RTL and testbench
================================

EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL expose parameter DATA_W, 32, narrow datapath width for ALU result, Rt and Rs data.
REQ-002 The block SHALL expose parameter WIDE_W, 64, wide datapath width for 64-bit ALU result and Rt data.
REQ-003 The block SHALL expose parameter WB_W, 10, writeback control bundle width.
REQ-004 The block SHALL expose parameter REG_W, 5, destination register index width.
REQ-005 The block SHALL expose parameter CNT_W, 16, stall counter width.

Ports (name direction width meaning):
REQ-006 The block SHALL have ports Clk input 1 clock (rising edge); one clock; reset is asynchronous and active-high; Rst input 1 reset.
REQ-007 The block SHALL have ports in_valid input 1, in_ready output 1, flush input 1: EXE-side handshake and squash request.
REQ-008 The block SHALL have EXE-side payload inputs OUT_ALU64 WIDE_W, OUT_ALU32 DATA_W, Rt_data64_EXE WIDE_W, Rt_data_EXE DATA_W, Rs_data_EXE DATA_W, RegWr_EXE REG_W, WB_control_EX WB_W, and MEM_control_EX 3 ({MemRead, MemWrite, MemWrite64}).
REQ-009 The block SHALL have MEM-side payload outputs OUT_ALU64_MEM, Adrs_MEM, Rt_data64_MEM, Rt_data_MEM, HILO_write_MEM, RegWr_MEM, and WB_control_MEM, each the width of its input.
REQ-010 The block SHALL have outputs out_valid 1, MemRead 1, MemWrite 1, MemWrite64 1, stall_cnt CNT_W, and input out_ready 1.

Function
REQ-011 Storage SHALL be a 2-entry skid buffer: main entry drives outputs; skid entry holds one overflow beat.
REQ-012 in_ready SHALL be registered and equal to NOT skid_valid, with no combinational path from out_ready.
REQ-013 A beat SHALL be accepted at a rising edge when in_valid AND in_ready; it is delivered when out_valid AND out_ready.
REQ-014 Latency SHALL be 1 cycle (accept at edge N, visible at outputs after edge N); throughput SHALL be 1 beat/cycle while out_ready is high.
REQ-015 Accept with main empty, or with main delivered the same edge and skid empty: the beat SHALL load main.
REQ-016 Accept while main is full and not delivered: the beat SHALL load skid and in_ready SHALL drop next cycle.
REQ-017 Delivery with skid full: skid SHALL move to main and skid_valid SHALL clear; in_ready SHALL be 1 next cycle.
REQ-018 Beat order SHALL be preserved; no beat is dropped or duplicated except by flush.
REQ-019 flush SHALL clear main_valid and skid_valid at the edge and discard any beat offered that cycle; flush SHALL override accept and delivery.
REQ-020 MemRead, MemWrite, and MemWrite64 SHALL equal main mem_ctrl bits [2], [1], and [0] ANDed with out_valid; invalid entries never issue memory strobes.
REQ-021 Adrs_MEM SHALL carry OUT_ALU32, and HILO_write_MEM SHALL carry Rs_data_EXE, unmodified.
REQ-022 stall_cnt SHALL increment each cycle out_valid AND NOT out_ready, saturating at 2^CNT_W-1; it SHALL clear only on Rst.
REQ-023 Payload registers SHALL load only on accept or skid-to-main transfer; a held beat SHALL stay stable while out_valid AND NOT out_ready.

Reset
REQ-024 On Rst high, asynchronously: both valids 0, all payload registers 0, stall_cnt 0, in_ready 1, all Mem strobes 0.
REQ-025 Rst asserted mid-transfer SHALL drop all buffered beats; the first accept after Rst release SHALL be honoured on the first rising edge.

Structure
REQ-026 Package exe_mem_pkg SHALL hold MEM_CTRL bit-index constants (MEMRD=2, MEMWR=1, MEMWR64=0) and default width constants.
REQ-027 The payload SHALL be packed into one vector; one sub-module pipe_skid_reg (parameter W) SHALL implement the 2-entry buffer, and the top SHALL add strobe gating and the counter.

Verification
REQ-028 Streaming: out_ready=1; send OUT_ALU32=0x10,0x14,0x18 back-to-back -> Adrs_MEM=0x10,0x14,0x18 on 3 consecutive cycles after 1-cycle latency; in_ready stays 1.
REQ-029 Backpressure: out_ready=0 with 2 beats A=0xA, B=0xB sent -> main=A, skid=B, in_ready=0, stall_cnt increments each cycle; out_ready=1 -> A then B delivered, in_ready=1.
REQ-030 Flush: skid full, flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, MemWrite=0, in_ready=1, offered beat absent.
REQ-031 Strobe gating: MEM_control_EX=3'b110 accepted -> MemRead=1, MemWrite=1, MemWrite64=0 while valid; all 0 after delivery with no new beat.
REQ-032 Reset mid-operation: Rst pulse while both entries full -> outputs 0 immediately (no clock edge), stall_cnt=0, in_ready=1.
REQ-033 Saturation: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15, no wrap.

Source files
------------

// File: rtl/exe_mem_pkg.sv
// rtl/exe_mem_pkg.sv - shared constants for the EXE/MEM pipeline register
// Purpose: memory-control bit positions and default datapath widths used by
//          exe_mem_stage and its testbench.
// Ports:   none (package).
package exe_mem_pkg;

  // Bit positions inside the 3-bit {MemRead, MemWrite, MemWrite64} bundle.
  localparam int MEMRD      = 2;
  localparam int MEMWR      = 1;
  localparam int MEMWR64    = 0;
  localparam int MEM_CTRL_W = 3;

  // Default widths.
  localparam int DATA_W_DEF = 32;
  localparam int WIDE_W_DEF = 64;
  localparam int WB_W_DEF   = 10;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W_DEF  = 16;

  typedef logic [MEM_CTRL_W-1:0] mem_ctrl_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - 2-entry skid buffer for a packed payload
// Purpose: registered-ready pipeline register; main entry drives the output,
//          skid entry absorbs the one beat accepted while main is stalled.
// Ports:   clk, rst (async, active-high), flush (drops both entries),
//          in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//          (downstream).
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic         in_ready_q;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         deliver;

  always_comb begin
    accept  = in_valid & in_ready_q;
    deliver = main_valid & out_ready;
  end

  // in_ready_q always tracks !skid_valid for the coming cycle, so the
  // upstream ready never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (!main_valid || deliver) begin
      // Main frees up this edge: the older skid beat has priority. While
      // skid is full in_ready_q is low, so no new beat can collide with it.
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (accept) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/exe_mem_stage.sv
// rtl/exe_mem_stage.sv - EXE/MEM pipeline register with skid buffering
// Purpose: carries the EXE results to the MEM stage through a 2-entry skid
//          buffer, gates memory strobes with validity and counts stall cycles.
// Ports:   Clk, Rst (async, active-high); in_valid/in_ready/flush and EXE
//          payload inputs; out_valid/out_ready and MEM payload outputs;
//          MemRead/MemWrite/MemWrite64 strobes; stall_cnt.
module exe_mem_stage
  import exe_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WIDE_W = WIDE_W_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [WIDE_W-1:0] OUT_ALU64,
  input  logic [DATA_W-1:0] OUT_ALU32,
  input  logic [WIDE_W-1:0] Rt_data64_EXE,
  input  logic [DATA_W-1:0] Rt_data_EXE,
  input  logic [DATA_W-1:0] Rs_data_EXE,
  input  logic [REG_W-1:0]  RegWr_EXE,
  input  logic [WB_W-1:0]   WB_control_EX,
  input  logic [2:0]        MEM_control_EX,
  output logic [WIDE_W-1:0] OUT_ALU64_MEM,
  output logic [DATA_W-1:0] Adrs_MEM,
  output logic [WIDE_W-1:0] Rt_data64_MEM,
  output logic [DATA_W-1:0] Rt_data_MEM,
  output logic [DATA_W-1:0] HILO_write_MEM,
  output logic [REG_W-1:0]  RegWr_MEM,
  output logic [WB_W-1:0]   WB_control_MEM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemWrite64,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = 2 * WIDE_W + 3 * DATA_W + REG_W + WB_W + MEM_CTRL_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  mem_ctrl_t     mem_ctrl_q;

  assign in_payload = {OUT_ALU64, OUT_ALU32, Rt_data64_EXE, Rt_data_EXE,
                       Rs_data_EXE, RegWr_EXE, WB_control_EX, MEM_control_EX};

  pipe_skid_reg #(.W(PW)) u_buf (
    .clk       (Clk),
    .rst       (Rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {OUT_ALU64_MEM, Adrs_MEM, Rt_data64_MEM, Rt_data_MEM,
          HILO_write_MEM, RegWr_MEM, WB_control_MEM, mem_ctrl_q} = out_payload;

  // A stale or flushed entry must never reach memory as a strobe.
  assign MemRead    = mem_ctrl_q[MEMRD]   & out_valid;
  assign MemWrite   = mem_ctrl_q[MEMWR]   & out_valid;
  assign MemWrite64 = mem_ctrl_q[MEMWR64] & out_valid;

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
// tb/tb_exe_mem_stage.sv - self-checking bench for exe_mem_stage
// Purpose: directed scenarios followed by random traffic, all checked against
//          a queue-based model of an in-order, 2-deep buffered stage.
// Ports:   none (top-level bench).
module tb_exe_mem_stage;

  localparam int CNT_W = 4;

  typedef struct {
    logic [63:0] alu64;
    logic [31:0] alu32;
    logic [63:0] rt64;
    logic [31:0] rt;
    logic [31:0] rs;
    logic [4:0]  regwr;
    logic [9:0]  wb;
    logic [2:0]  mem;
  } beat_t;

  logic             Clk, Rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0]      OUT_ALU64, Rt_data64_EXE, OUT_ALU64_MEM, Rt_data64_MEM;
  logic [31:0]      OUT_ALU32, Rt_data_EXE, Rs_data_EXE;
  logic [31:0]      Adrs_MEM, Rt_data_MEM, HILO_write_MEM;
  logic [4:0]       RegWr_EXE, RegWr_MEM;
  logic [9:0]       WB_control_EX, WB_control_MEM;
  logic [2:0]       MEM_control_EX;
  logic             MemRead, MemWrite, MemWrite64;
  logic [CNT_W-1:0] stall_cnt;

  exe_mem_stage #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .OUT_ALU64(OUT_ALU64), .OUT_ALU32(OUT_ALU32), .Rt_data64_EXE(Rt_data64_EXE),
    .Rt_data_EXE(Rt_data_EXE), .Rs_data_EXE(Rs_data_EXE), .RegWr_EXE(RegWr_EXE),
    .WB_control_EX(WB_control_EX), .MEM_control_EX(MEM_control_EX),
    .OUT_ALU64_MEM(OUT_ALU64_MEM), .Adrs_MEM(Adrs_MEM), .Rt_data64_MEM(Rt_data64_MEM),
    .Rt_data_MEM(Rt_data_MEM), .HILO_write_MEM(HILO_write_MEM), .RegWr_MEM(RegWr_MEM),
    .WB_control_MEM(WB_control_MEM), .out_valid(out_valid), .out_ready(out_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemWrite64(MemWrite64), .stall_cnt(stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  beat_t q[$];
  int    exp_stall;
  int    n_vec;
  int    n_err;
  beat_t cur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.alu64 = {$urandom, $urandom};
    b.alu32 = $urandom;
    b.rt64  = {$urandom, $urandom};
    b.rt    = $urandom;
    b.rs    = $urandom;
    b.regwr = 5'($urandom);
    b.wb    = 10'($urandom);
    b.mem   = 3'($urandom);
    return b;
  endfunction

  task automatic drive(input logic v, input beat_t b, input logic fl, input logic rdy);
    in_valid       = v;
    OUT_ALU64      = b.alu64;
    OUT_ALU32      = b.alu32;
    Rt_data64_EXE  = b.rt64;
    Rt_data_EXE    = b.rt;
    Rs_data_EXE    = b.rs;
    RegWr_EXE      = b.regwr;
    WB_control_EX  = b.wb;
    MEM_control_EX = b.mem;
    flush          = fl;
    out_ready      = rdy;
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    if (q.size() > 0) begin
      chk("OUT_ALU64_MEM", OUT_ALU64_MEM, q[0].alu64);
      chk("Adrs_MEM", 64'(Adrs_MEM), 64'(q[0].alu32));
      chk("Rt_data64_MEM", Rt_data64_MEM, q[0].rt64);
      chk("Rt_data_MEM", 64'(Rt_data_MEM), 64'(q[0].rt));
      chk("HILO_write_MEM", 64'(HILO_write_MEM), 64'(q[0].rs));
      chk("RegWr_MEM", 64'(RegWr_MEM), 64'(q[0].regwr));
      chk("WB_control_MEM", 64'(WB_control_MEM), 64'(q[0].wb));
    end
    chk("MemRead", 64'(MemRead), 64'(q.size() > 0 && q[0].mem[2]));
    chk("MemWrite", 64'(MemWrite), 64'(q.size() > 0 && q[0].mem[1]));
    chk("MemWrite64", 64'(MemWrite64), 64'(q.size() > 0 && q[0].mem[0]));
  endtask

  // One clock: the model consumes the pre-edge inputs and occupancy, then
  // the DUT outputs are compared 1 time unit after the edge.
  task automatic cycle();
    bit acc, dlv;
    @(posedge Clk);
    acc = in_valid && (q.size() < 2);
    dlv = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready && exp_stall < (1 << CNT_W) - 1) exp_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    #1;
    check_all();
  endtask

  task automatic send(input logic v, input logic fl, input logic rdy);
    cur = rand_beat();
    drive(v, cur, fl, rdy);
    cycle();
  endtask

  task automatic send_addr(input logic [31:0] a, input logic rdy);
    cur = rand_beat();
    cur.alu32 = a;
    drive(1'b1, cur, 1'b0, rdy);
    cycle();
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock.
  task automatic async_reset();
    #2;
    Rst = 1'b1;
    #1;
    q.delete();
    exp_stall = 0;
    check_all();
    chk("rst_Adrs_MEM", 64'(Adrs_MEM), 64'd0);
    chk("rst_OUT_ALU64_MEM", OUT_ALU64_MEM, 64'd0);
    drive(1'b0, rand_beat(), 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_stall = 0;
    Rst = 1'b1;
    drive(1'b0, rand_beat(), 1'b0, 1'b1);
    #1;
    check_all();
    chk("rst_WB_control_MEM", 64'(WB_control_MEM), 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Streaming: three back-to-back beats with ready held high.
    send_addr(32'h10, 1'b1);
    chk("stream_a0", 64'(Adrs_MEM), 64'h10);
    send_addr(32'h14, 1'b1);
    chk("stream_a1", 64'(Adrs_MEM), 64'h14);
    send_addr(32'h18, 1'b1);
    chk("stream_a2", 64'(Adrs_MEM), 64'h18);
    send(1'b0, 1'b0, 1'b1);

    // Backpressure: A lands in main, B in skid, then both drain in order.
    send_addr(32'hA, 1'b0);
    send_addr(32'hB, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    chk("bp_b_out", 64'(Adrs_MEM), 64'hB);
    send(1'b0, 1'b0, 1'b1);

    // Strobe gating: 3'b110 gives read+write while valid, nothing afterwards.
    cur = rand_beat();
    cur.mem = 3'b110;
    drive(1'b1, cur, 1'b0, 1'b0);
    cycle();
    chk("strobe_rd", 64'(MemRead), 64'd1);
    send(1'b0, 1'b0, 1'b1);
    chk("strobe_wr_off", 64'(MemWrite), 64'd0);

    // Flush with skid full and a beat offered in the same cycle.
    cur = rand_beat();
    cur.mem = 3'b010;
    drive(1'b1, cur, 1'b0, 1'b0);
    cycle();
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // Reset with both entries full, then an accept on the first edge after.
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    async_reset();
    send(1'b1, 1'b0, 1'b1);

    // Saturation: 20 stalled cycles on a 4-bit counter stop at 15.
    send(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0, 1'b0);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) async_reset();
      else send($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
